// File: rtl/relay_chain_timed.sv
// Series chain of STAGES timed relays: each armature has pull-in/drop-out delays,
// each contact feeds the next stage's supply, and output edges are counted.
module relay_chain_timed #(
  parameter int                STAGES   = 4,
  parameter int                PULL_IN  = 3,
  parameter int                DROP_OUT = 2,
  parameter logic [STAGES-1:0] NC_MASK  = '0,
  parameter int                TW       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              batt,
  input  logic [STAGES-1:0] switch,
  output logic [STAGES-1:0] armature,
  output logic [STAGES-1:0] v,
  output logic              out,
  output logic              settled,
  output logic [TW-1:0]     transitions
);

  localparam int MAXD = (PULL_IN > DROP_OUT) ? PULL_IN : DROP_OUT;
  localparam int CW   = $clog2(MAXD + 1);
  localparam logic [CW-1:0] PI_LAST = CW'(PULL_IN - 1);
  localparam logic [CW-1:0] DO_LAST = CW'(DROP_OUT - 1);

  typedef enum logic [1:0] {OPEN, PULLING, CLOSED, DROPPING} relay_st_t;

  relay_st_t     st_q  [STAGES];
  relay_st_t     st_d  [STAGES];
  logic [CW-1:0] cnt_q [STAGES];
  logic [CW-1:0] cnt_d [STAGES];
  logic          prev_out;
  logic          chain;

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        OPEN: begin
          if (switch[i]) begin
            if (PULL_IN == 1) begin
              st_d[i] = CLOSED;
            end else begin
              st_d[i]  = PULLING;
              cnt_d[i] = CW'(1);
            end
          end
        end
        PULLING: begin
          // Any low sample aborts the pull; timing restarts from scratch.
          if (!switch[i]) begin
            st_d[i]  = OPEN;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == PI_LAST) begin
            st_d[i]  = CLOSED;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        CLOSED: begin
          if (!switch[i]) begin
            if (DROP_OUT == 1) begin
              st_d[i] = OPEN;
            end else begin
              st_d[i]  = DROPPING;
              cnt_d[i] = CW'(1);
            end
          end
        end
        DROPPING: begin
          if (switch[i]) begin
            st_d[i]  = CLOSED;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DO_LAST) begin
            st_d[i]  = OPEN;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          st_d[i]  = OPEN;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        st_q[i]  <= OPEN;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    armature = '0;
    settled  = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      armature[i] = (st_q[i] == CLOSED) || (st_q[i] == DROPPING);
      if ((st_q[i] == PULLING) || (st_q[i] == DROPPING)) settled = 1'b0;
    end
  end

  // Supply ripples through every contact; an NC contact conducts while released.
  always_comb begin
    v     = '0;
    chain = batt;
    for (int i = 0; i < STAGES; i++) begin
      chain = chain & (armature[i] ^ NC_MASK[i]);
      v[i]  = chain;
    end
  end

  assign out = v[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_out    <= 1'b0;
      transitions <= '0;
    end else begin
      prev_out <= out;
      if ((out != prev_out) && (transitions != '1)) transitions <= transitions + TW'(1);
    end
  end

endmodule

// File: tb/tb_relay_chain_timed.sv
// Bench for relay_chain_timed: a series instance and an inverter/saturation
// instance, checked each cycle against a run-length relay model via a scoreboard.
module tb_relay_chain_timed;

  logic       clk;
  logic       rst_n;
  logic       batt;
  logic [1:0] sw_s, sw_i;
  logic [1:0] arm_s, v_s, arm_i, v_i;
  logic       out_s, set_s, out_i, set_i;
  logic [7:0] tr_s;
  logic [1:0] tr_i;

  relay_chain_timed #(.STAGES(2), .PULL_IN(3), .DROP_OUT(2), .NC_MASK(2'b00), .TW(8)) u_ser (
    .clk(clk), .rst_n(rst_n), .batt(batt), .switch(sw_s), .armature(arm_s), .v(v_s),
    .out(out_s), .settled(set_s), .transitions(tr_s));

  relay_chain_timed #(.STAGES(2), .PULL_IN(3), .DROP_OUT(2), .NC_MASK(2'b10), .TW(2)) u_inv (
    .clk(clk), .rst_n(rst_n), .batt(batt), .switch(sw_i), .armature(arm_i), .v(v_i),
    .out(out_i), .settled(set_i), .transitions(tr_i));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [1:0] arm;
    logic [1:0] v;
    logic       settled;
    int         tr;
  } exp_t;

  exp_t       sbq[$];
  logic [1:0] m_arm [2];
  int         m_hi  [2][2];
  int         m_lo  [2][2];
  logic       m_prev[2];
  int         m_tr  [2];
  int         total, bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_v(input int k);
    logic [1:0] nc;
    logic [1:0] r;
    logic       run;
    nc  = (k == 1) ? 2'b10 : 2'b00;
    run = batt;
    r   = '0;
    for (int i = 0; i < 2; i++) begin
      run  = run & (nc[i] ? ~m_arm[k][i] : m_arm[k][i]);
      r[i] = run;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_arm[k]  = '0;
      m_prev[k] = 1'b0;
      m_tr[k]   = 0;
      for (int i = 0; i < 2; i++) begin
        m_hi[k][i] = 0;
        m_lo[k][i] = 0;
      end
    end
    sbq.delete();
  endtask

  // Predicts the state right after the next rising edge given the coil drive.
  task automatic m_edge(input int k, input logic [1:0] sw);
    logic [1:0] vv;
    logic       setl;
    int         tmax;
    exp_t       e;
    tmax = (k == 0) ? 255 : 3;
    vv   = m_v(k);
    if ((vv[1] != m_prev[k]) && (m_tr[k] < tmax)) m_tr[k]++;
    m_prev[k] = vv[1];
    setl = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (sw[i]) begin
        m_hi[k][i]++;
        m_lo[k][i] = 0;
      end else begin
        m_lo[k][i]++;
        m_hi[k][i] = 0;
      end
      if (!m_arm[k][i] && (m_hi[k][i] >= 3)) m_arm[k][i] = 1'b1;
      else if (m_arm[k][i] && (m_lo[k][i] >= 2)) m_arm[k][i] = 1'b0;
      if ((!m_arm[k][i] && (m_hi[k][i] > 0)) || (m_arm[k][i] && (m_lo[k][i] > 0))) setl = 1'b0;
    end
    e.k = k; e.arm = m_arm[k]; e.v = m_v(k); e.settled = setl; e.tr = m_tr[k];
    sbq.push_back(e);
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    sw_s = a;
    sw_i = b;
    m_edge(0, a);
    m_edge(1, b);
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.k == 0) begin
        chk("ser.arm", arm_s, e.arm);
        chk("ser.v", v_s, e.v);
        chk("ser.out", out_s, e.v[1]);
        chk("ser.settled", set_s, e.settled);
        chk("ser.tr", tr_s, e.tr);
      end else begin
        chk("inv.arm", arm_i, e.arm);
        chk("inv.v", v_i, e.v);
        chk("inv.out", out_i, e.v[1]);
        chk("inv.settled", set_i, e.settled);
        chk("inv.tr", tr_i, e.tr);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int   sat_exp[6];
    logic lvl;
    sat_exp = '{0, 1, 2, 3, 3, 3};
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    batt  = 1'b1;
    sw_s  = '0;
    sw_i  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.arm", arm_s, 2'b00);
    chk("rst.settled", set_s, 1);
    chk("rst.tr", tr_s, 0);
    chk("rst.inv_v", v_i, 2'b00);
    rst_n = 1'b1;

    // Series baseline
    step(2'b11, 2'b00); chk("t1.settled_e1", set_s, 0);
    step(2'b11, 2'b00); chk("t1.settled_e2", set_s, 0); chk("t1.arm_e2", arm_s, 2'b00);
    step(2'b11, 2'b00); chk("t1.arm_e3", arm_s, 2'b11); chk("t1.out_e3", out_s, 1);
    chk("t1.settled_e3", set_s, 1);
    repeat (2) step(2'b11, 2'b00);
    chk("t1.tr", tr_s, 1);

    // Series gating
    repeat (4) step(2'b00, 2'b00);
    chk("t2.open", arm_s, 2'b00);
    repeat (3) step(2'b10, 2'b00);
    chk("t2.arm1", arm_s, 2'b10); chk("t2.out_gated", out_s, 0);
    repeat (2) step(2'b11, 2'b00);
    chk("t2.out_e2", out_s, 0);
    step(2'b11, 2'b00);
    chk("t2.out_e3", out_s, 1);

    // Bounce rejection and glitch immunity
    repeat (3) step(2'b00, 2'b00);
    chk("t3.tr_before", tr_s, 4);
    repeat (2) begin step(2'b01, 2'b00); chk("t3.bounce_arm0", arm_s[0], 0); end
    repeat (3) begin step(2'b00, 2'b00); chk("t3.after_arm0", arm_s[0], 0); end
    chk("t3.settled", set_s, 1);
    chk("t3.tr_unchanged", tr_s, 4);
    repeat (4) step(2'b11, 2'b00);
    chk("t3.closed", arm_s, 2'b11);
    step(2'b01, 2'b00);
    chk("t3.glitch_arm", arm_s, 2'b11); chk("t3.glitch_out", out_s, 1);
    repeat (3) begin
      step(2'b11, 2'b00);
      chk("t3.hold_arm", arm_s, 2'b11); chk("t3.hold_out", out_s, 1);
    end
    batt = 1'b0;
    step(2'b11, 2'b00); chk("t3.batt_off_out", out_s, 0); chk("t3.batt_off_arm", arm_s, 2'b11);
    batt = 1'b1;
    step(2'b11, 2'b00); chk("t3.batt_tr", tr_s, 7);

    // Inverter stage on the NC instance
    repeat (3) step(2'b11, 2'b01);
    chk("t4.out_batt", out_i, 1);
    repeat (2) step(2'b11, 2'b11);
    chk("t4.out_e2", out_i, 1);
    step(2'b11, 2'b11);
    chk("t4.out_inv", out_i, 0);
    step(2'b11, 2'b01); chk("t4.out_d1", out_i, 0);
    step(2'b11, 2'b01); chk("t4.out_d2", out_i, 1);
    step(2'b11, 2'b01);
    // one extra count for the initial rise when stage 0 closed
    chk("t4.tr", tr_i, 3);

    // Reset in the middle of a pull
    repeat (3) step(2'b00, 2'b00);
    repeat (2) step(2'b01, 2'b00);
    chk("t5.pulling", set_s, 0);
    rst_n = 1'b0;
    #1;
    chk("t5.rst_arm", arm_s, 2'b00);
    chk("t5.rst_settled", set_s, 1);
    chk("t5.rst_tr", tr_s, 0);
    chk("t5.rst_inv_tr", tr_i, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(2'b01, 2'b00);
    chk("t5.fresh_e2", arm_s[0], 0);
    step(2'b01, 2'b00);
    chk("t5.fresh_e3", arm_s[0], 1);

    // Saturating counter on the TW=2 instance
    lvl = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk("t6.sat", tr_i, sat_exp[j]);
      lvl = ~lvl;
      repeat (5) step(2'b01, {1'b0, lvl});
    end
    chk("t6.sat_end", tr_i, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
